// File: rtl/collision_matrix.sv
// Ball-vs-object collision detector: per-channel edge/level pulses, multi-frame cooldown,
// previous-frame hit flags, saturating frames-with-hit counters and first-hit-of-frame index.
module collision_matrix #(
  parameter int NUM_OBJ         = 8,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int CNT_W           = 8,
  localparam int IDX_W          = $clog2(NUM_OBJ)
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     drawBall,
  input  logic [NUM_OBJ-1:0]       drawObj,
  input  logic [NUM_OBJ-1:0]       objEnable,
  input  logic [NUM_OBJ-1:0]       modeLevel,
  input  logic                     clrCounts,
  output logic [NUM_OBJ-1:0]       collisionPulse,
  output logic [NUM_OBJ-1:0]       frameFlags,
  output logic [NUM_OBJ*CNT_W-1:0] hitCount,
  output logic [IDX_W-1:0]         firstHitIdx,
  output logic                     firstHitValid
);

  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  logic [NUM_OBJ-1:0] raw;
  logic [NUM_OBJ-1:0] seen;
  logic [CD_W-1:0]    cd [NUM_OBJ];
  logic [CNT_W-1:0]   cnt [NUM_OBJ];
  logic [IDX_W-1:0]   lowIdx;

  // Draw inputs are blanked during the frame strobe so no pulse can race the per-frame bookkeeping.
  always_comb begin
    raw = {NUM_OBJ{drawBall & ~startOfFrame}} & drawObj & objEnable;
    collisionPulse = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (modeLevel[i])
        collisionPulse[i] = raw[i];
      else
        collisionPulse[i] = raw[i] & ~seen[i] & (cd[i] == '0);
    end
  end

  // Scanning downward leaves the lowest pulsing channel as the winner.
  always_comb begin
    lowIdx = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (collisionPulse[i])
        lowIdx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      seen          <= '0;
      frameFlags    <= '0;
      firstHitIdx   <= '0;
      firstHitValid <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        cd[i]  <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (startOfFrame) begin
        seen          <= '0;
        frameFlags    <= seen;
        firstHitValid <= 1'b0;
      end else begin
        seen <= seen | collisionPulse;
        if (!firstHitValid && (|collisionPulse)) begin
          firstHitValid <= 1'b1;
          firstHitIdx   <= lowIdx;
        end
      end
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (startOfFrame) begin
          if (!modeLevel[i] && seen[i])
            cd[i] <= CD_W'(COOLDOWN_FRAMES);
          else if (cd[i] != '0)
            cd[i] <= cd[i] - CD_W'(1);
        end
        // A clear wins over a same-cycle increment.
        if (clrCounts)
          cnt[i] <= '0;
        else if (startOfFrame && seen[i] && (cnt[i] != '1))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : gCount
    assign hitCount[g*CNT_W +: CNT_W] = cnt[g];
  end

endmodule

// File: tb/tb_collision_matrix.sv
// Directed bench for collision_matrix: a vector table for single-cycle behaviour plus
// hand-written multi-frame sequences for cooldown, saturation, first-hit and reset.
module tb_collision_matrix;

  localparam int NUM_OBJ = 8;
  localparam int CNT_W   = 2;

  logic                     clk = 1'b0;
  logic                     resetN;
  logic                     startOfFrame;
  logic                     drawBall;
  logic [NUM_OBJ-1:0]       drawObj;
  logic [NUM_OBJ-1:0]       objEnable;
  logic [NUM_OBJ-1:0]       modeLevel;
  logic                     clrCounts;
  logic [NUM_OBJ-1:0]       collisionPulse;
  logic [NUM_OBJ-1:0]       frameFlags;
  logic [NUM_OBJ*CNT_W-1:0] hitCount;
  logic [2:0]               firstHitIdx;
  logic                     firstHitValid;

  int errors = 0;
  int checks = 0;

  collision_matrix #(.NUM_OBJ(NUM_OBJ), .COOLDOWN_FRAMES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drawBall(drawBall),
    .drawObj(drawObj), .objEnable(objEnable), .modeLevel(modeLevel), .clrCounts(clrCounts),
    .collisionPulse(collisionPulse), .frameFlags(frameFlags), .hitCount(hitCount),
    .firstHitIdx(firstHitIdx), .firstHitValid(firstHitValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       sof;
    logic       ball;
    logic [7:0] obj;
    logic [7:0] en;
    logic [7:0] mode;
    logic [7:0] expPulse;
    logic       expValid;
    logic [2:0] expIdx;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sof, input logic ball, input logic [7:0] obj,
                               input logic [7:0] en, input logic [7:0] mode);
    startOfFrame = sof;
    drawBall     = ball;
    drawObj      = obj;
    objEnable    = en;
    modeLevel    = mode;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
    clrCounts = 1'b0;
    resetN    = 1'b0;
    step();
    resetN = 1'b1;
  endtask

  task automatic endFrame(input logic clr);
    applyStimulus(1'b1, 1'b0, 8'h00, objEnable, modeLevel);
    clrCounts = clr;
    step();
    clrCounts    = 1'b0;
    startOfFrame = 1'b0;
  endtask

  function automatic logic [1:0] cntOf(input int ch);
    return hitCount[ch*CNT_W +: CNT_W];
  endfunction

  initial begin
    vecs[0] = '{"single ch2",     1'b0, 1'b1, 8'h04, 8'hFF, 8'h00, 8'h04, 1'b1, 3'd2};
    vecs[1] = '{"no ball",        1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 3'd0};
    vecs[2] = '{"enable mask",    1'b0, 1'b1, 8'hFF, 8'h0F, 8'h00, 8'h0F, 1'b1, 3'd0};
    vecs[3] = '{"multi low2",     1'b0, 1'b1, 8'hA4, 8'hFF, 8'h00, 8'hA4, 1'b1, 3'd2};
    vecs[4] = '{"level upper",    1'b0, 1'b1, 8'hFF, 8'hF0, 8'hFF, 8'hF0, 1'b1, 3'd4};
    vecs[5] = '{"no objects",     1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 3'd0};
    vecs[6] = '{"sof blanks",     1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 3'd0};

    doReset();
    checkOutput("reset frameFlags", 32'(frameFlags), 32'h0);
    checkOutput("reset hitCount", 32'(hitCount), 32'h0);
    checkOutput("reset firstHitValid", 32'(firstHitValid), 32'h0);
    checkOutput("reset firstHitIdx", 32'(firstHitIdx), 32'h0);

    for (int v = 0; v < 7; v++) begin
      doReset();
      applyStimulus(vecs[v].sof, vecs[v].ball, vecs[v].obj, vecs[v].en, vecs[v].mode);
      #1;
      checkOutput({vecs[v].name, " pulse"}, 32'(collisionPulse), 32'(vecs[v].expPulse));
      step();
      checkOutput({vecs[v].name, " valid"}, 32'(firstHitValid), 32'(vecs[v].expValid));
      checkOutput({vecs[v].name, " idx"}, 32'(firstHitIdx), 32'(vecs[v].expIdx));
    end

    // ch2 edge mode held for five pixels pulses once only
    doReset();
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b0, 1'b1, 8'h04, 8'hFF, 8'h00);
      #1;
      checkOutput($sformatf("ch2 edge pixel%0d", p), 32'(collisionPulse), (p == 0) ? 32'h04 : 32'h0);
      step();
    end
    endFrame(1'b0);
    checkOutput("ch2 frameFlags", 32'(frameFlags), 32'h04);
    checkOutput("ch2 hitCount", 32'(cntOf(2)), 32'h1);

    // ch3 edge mode with cooldown of two frames
    doReset();
    for (int f = 0; f < 5; f++) begin
      applyStimulus(1'b0, 1'b1, 8'h08, 8'hFF, 8'h00);
      #1;
      checkOutput($sformatf("ch3 cooldown frame%0d", f), 32'(collisionPulse),
                  (f == 0 || f == 3) ? 32'h08 : 32'h0);
      step();
      endFrame(1'b0);
      if (f == 0) checkOutput("ch3 hitCount frame0", 32'(cntOf(3)), 32'h1);
      if (f == 2) checkOutput("ch3 hitCount frame2", 32'(cntOf(3)), 32'h1);
    end
    checkOutput("ch3 hitCount end", 32'(cntOf(3)), 32'h2);

    // ch5 level mode: every overlapping pixel pulses, no cooldown
    doReset();
    for (int p = 0; p < 4; p++) begin
      applyStimulus(1'b0, 1'b1, 8'h20, 8'hFF, 8'h20);
      #1;
      checkOutput($sformatf("ch5 level pixel%0d", p), 32'(collisionPulse), 32'h20);
      step();
    end
    endFrame(1'b0);
    checkOutput("ch5 frameFlags", 32'(frameFlags), 32'h20);
    checkOutput("ch5 hitCount", 32'(cntOf(5)), 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h20, 8'hFF, 8'h20);
    #1;
    checkOutput("ch5 next frame pulse", 32'(collisionPulse), 32'h20);
    step();

    // ch1 and ch6 together, then ch0 later in the same frame
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h42, 8'hFF, 8'h00);
    #1;
    checkOutput("ch1ch6 pulse", 32'(collisionPulse), 32'h42);
    step();
    checkOutput("ch1ch6 valid", 32'(firstHitValid), 32'h1);
    checkOutput("ch1ch6 idx", 32'(firstHitIdx), 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'hFF, 8'h00);
    step();
    checkOutput("later ch0 idx held", 32'(firstHitIdx), 32'h1);
    checkOutput("later ch0 valid held", 32'(firstHitValid), 32'h1);
    endFrame(1'b0);
    checkOutput("sof clears valid", 32'(firstHitValid), 32'h0);
    checkOutput("sof keeps idx", 32'(firstHitIdx), 32'h1);

    // ch0 level mode over five frames saturates the 2-bit counter
    doReset();
    for (int f = 0; f < 5; f++) begin
      applyStimulus(1'b0, 1'b1, 8'h01, 8'hFF, 8'h01);
      step();
      endFrame(1'b0);
      checkOutput($sformatf("ch0 sat frame%0d", f), 32'(cntOf(0)), (f < 3) ? 32'(f + 1) : 32'h3);
    end
    applyStimulus(1'b0, 1'b1, 8'h01, 8'hFF, 8'h01);
    step();
    endFrame(1'b1);
    checkOutput("clr beats increment", 32'(cntOf(0)), 32'h0);

    // Reset mid-frame while ch4 is cooling down
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h10, 8'hFF, 8'h00);
    step();
    endFrame(1'b0);
    checkOutput("ch4 frameFlags", 32'(frameFlags), 32'h10);
    applyStimulus(1'b0, 1'b1, 8'h10, 8'hFF, 8'h00);
    #1;
    checkOutput("ch4 muted", 32'(collisionPulse), 32'h0);
    doReset();
    checkOutput("midreset frameFlags", 32'(frameFlags), 32'h0);
    checkOutput("midreset hitCount", 32'(hitCount), 32'h0);
    checkOutput("midreset valid", 32'(firstHitValid), 32'h0);
    checkOutput("midreset pulse", 32'(collisionPulse), 32'h0);
    endFrame(1'b0);
    applyStimulus(1'b0, 1'b1, 8'h10, 8'hFF, 8'h00);
    #1;
    checkOutput("ch4 after reset pulse", 32'(collisionPulse), 32'h10);
    step();

    // Disable mid-frame stops pulses immediately in level mode
    applyStimulus(1'b0, 1'b1, 8'h10, 8'hEF, 8'h10);
    #1;
    checkOutput("ch4 disabled", 32'(collisionPulse), 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
